// File: rtl/phrase_sequencer.sv
// Phrase sequencer: steps through a range of phrase-table addresses, latching
// each phrase ID and counting step ticks within the phrase. A phrase ends on
// its final step tick, followed by a one-cycle FETCH of the next entry.
// When the last address finishes, playback either loops or parks in DONE.
module phrase_sequencer #(
  parameter int FIRST_ADDR       = 1,
  parameter int LAST_ADDR        = 152,
  parameter int STEPS_PER_PHRASE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic       step_tick,
  input  logic [4:0] db_entry,
  output logic [7:0] db_addr,
  output logic [4:0] phrase_id,
  output logic [3:0] step_idx,
  output logic       phrase_valid,
  output logic       busy,
  output logic       song_done
);

  localparam logic [7:0] FIRST_A   = 8'(FIRST_ADDR);
  localparam logic [7:0] LAST_A    = 8'(LAST_ADDR);
  localparam logic [3:0] LAST_STEP = 4'(STEPS_PER_PHRASE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] db_addr_q, db_addr_d;
  logic [4:0] phrase_id_q, phrase_id_d;
  logic [3:0] step_idx_q, step_idx_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pend_q, pend_d;
  logic       tick_eff_s;

  // A tick owed from the FETCH cycle counts as a tick on the next PLAY cycle.
  assign tick_eff_s = step_tick | pend_q;

  // State register and all registered outputs; reset is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      db_addr_q   <= 8'd0;
      phrase_id_q <= 5'd0;
      step_idx_q  <= 4'd0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_addr_q   <= db_addr_d;
      phrase_id_q <= phrase_id_d;
      step_idx_q  <= step_idx_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
    end
  end

  // Next-state and next-output logic; stop overrides every other request.
  always_comb begin
    state_d     = state_q;
    db_addr_d   = db_addr_q;
    phrase_id_d = phrase_id_q;
    step_idx_d  = step_idx_q;
    valid_d     = valid_q;
    pend_d      = pend_q;

    if (stop) begin
      state_d    = S_IDLE;
      valid_d    = 1'b0;
      step_idx_d = 4'd0;
      pend_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d    = S_FETCH;
            db_addr_d  = FIRST_A;
            step_idx_d = 4'd0;
            valid_d    = 1'b0;
            pend_d     = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        S_FETCH: begin
          // db_entry already reflects db_addr_q; latch it and start playing.
          phrase_id_d = db_entry;
          step_idx_d  = 4'd0;
          valid_d     = 1'b1;
          pend_d      = pend_q | step_tick;
          state_d     = S_PLAY;
        end
        S_PLAY: begin
          // Two coincident ticks (owed + new) keep one owed for later.
          pend_d = step_tick & pend_q;
          if (tick_eff_s) begin
            if (step_idx_q == LAST_STEP) begin
              valid_d = 1'b0;
              if (db_addr_q < LAST_A) begin
                db_addr_d = db_addr_q + 8'd1;
                state_d   = S_FETCH;
              end else if (loop_en) begin
                db_addr_d = FIRST_A;
                state_d   = S_FETCH;
              end else begin
                state_d = S_DONE;
                pend_d  = 1'b0;
              end
            end else begin
              step_idx_d = step_idx_q + 4'd1;
            end
          end else begin
            step_idx_d = step_idx_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_PLAY);
    done_d = (state_d == S_DONE);
  end

  assign db_addr      = db_addr_q;
  assign phrase_id    = phrase_id_q;
  assign step_idx     = step_idx_q;
  assign phrase_valid = valid_q;
  assign busy         = busy_q;
  assign song_done    = done_q;

endmodule

// File: tb/tb_phrase_sequencer.sv
// Bench for phrase_sequencer: three instances (default song, single-phrase
// song at 152, two-phrase song ending at 255 with 2 steps per phrase) share
// the control inputs; a behavioural model of each is checked every cycle,
// and directed checks with hand-computed values pin the model.
module tb_phrase_sequencer;

  logic clk = 1'b0;
  logic rst_n, start, stop, loop_en, step_tick;
  logic [4:0] ent0, ent1, ent2, pid0, pid1, pid2;
  logic [7:0] addr0, addr1, addr2;
  logic [3:0] step0, step1, step2;
  logic v0, v1, v2, b0, b1, b2, d0, d1, d2;
  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  localparam int FA[3] = '{1, 152, 254};
  localparam int LA[3] = '{152, 152, 255};
  localparam int SP[3] = '{16, 16, 2};

  always #5 clk = ~clk;

  function automatic logic [4:0] tbl(input int a);
    case (a)
      1:       tbl = 5'd19;
      2:       tbl = 5'd20;
      152:     tbl = 5'd22;
      default: tbl = 5'((a * 7 + 3) % 32);
    endcase
  endfunction

  assign ent0 = tbl(int'(addr0));
  assign ent1 = tbl(int'(addr1));
  assign ent2 = tbl(int'(addr2));

  phrase_sequencer u0 (.clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .loop_en(loop_en), .step_tick(step_tick), .db_entry(ent0), .db_addr(addr0),
    .phrase_id(pid0), .step_idx(step0), .phrase_valid(v0), .busy(b0), .song_done(d0));
  phrase_sequencer #(.FIRST_ADDR(152), .LAST_ADDR(152), .STEPS_PER_PHRASE(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .loop_en(loop_en), .step_tick(step_tick), .db_entry(ent1), .db_addr(addr1),
    .phrase_id(pid1), .step_idx(step1), .phrase_valid(v1), .busy(b1), .song_done(d1));
  phrase_sequencer #(.FIRST_ADDR(254), .LAST_ADDR(255), .STEPS_PER_PHRASE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .loop_en(loop_en), .step_tick(step_tick), .db_entry(ent2), .db_addr(addr2),
    .phrase_id(pid2), .step_idx(step2), .phrase_valid(v2), .busy(b2), .song_done(d2));

  // Model: mode 0=idle 1=fetch 2=play 3=done; owed = ticks not yet applied.
  int m_mode[3], m_addr[3], m_pid[3], m_step[3], m_valid[3], m_owed[3];

  // Behavioural model: one tick per step, a phrase ends on its last step,
  // the next address is fetched in one cycle; stop aborts to idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_mode[k] <= 0; m_addr[k] <= 0; m_pid[k] <= 0;
        m_step[k] <= 0; m_valid[k] <= 0; m_owed[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (stop) begin
          m_mode[k] <= 0; m_valid[k] <= 0; m_step[k] <= 0; m_owed[k] <= 0;
        end else if (m_mode[k] == 0 || m_mode[k] == 3) begin
          if (start) begin
            m_mode[k] <= 1; m_addr[k] <= FA[k]; m_step[k] <= 0;
            m_valid[k] <= 0; m_owed[k] <= 0;
          end
        end else if (m_mode[k] == 1) begin
          m_pid[k] <= int'(tbl(m_addr[k])); m_valid[k] <= 1; m_step[k] <= 0;
          m_owed[k] <= (m_owed[k] + int'(step_tick) > 0) ? 1 : 0;
          m_mode[k] <= 2;
        end else if (m_owed[k] + int'(step_tick) > 0) begin
          m_owed[k] <= m_owed[k] + int'(step_tick) - 1;
          if (m_step[k] + 1 < SP[k]) begin
            m_step[k] <= m_step[k] + 1;
          end else begin
            m_valid[k] <= 0;
            if (m_addr[k] < LA[k]) begin
              m_addr[k] <= m_addr[k] + 1; m_mode[k] <= 1;
            end else if (loop_en) begin
              m_addr[k] <= FA[k]; m_mode[k] <= 1;
            end else begin
              m_mode[k] <= 3; m_owed[k] <= 0;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input int a, input int p, input int s,
                     input int v, input int b, input int d);
    chk($sformatf("i%0d_addr", k), a, m_addr[k]);
    chk($sformatf("i%0d_pid", k), p, m_pid[k]);
    chk($sformatf("i%0d_step", k), s, m_step[k]);
    chk($sformatf("i%0d_valid", k), v, m_valid[k]);
    chk($sformatf("i%0d_busy", k), b, (m_mode[k] == 1 || m_mode[k] == 2) ? 1 : 0);
    chk($sformatf("i%0d_done", k), d, (m_mode[k] == 3) ? 1 : 0);
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, int'(addr0), int'(pid0), int'(step0), int'(v0), int'(b0), int'(d0));
      cmp(1, int'(addr1), int'(pid1), int'(step1), int'(v1), int'(b1), int'(d1));
      cmp(2, int'(addr2), int'(pid2), int'(step2), int'(v2), int'(b2), int'(d2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; step_tick = 1'b0;
    #12;
    chk("rst_addr", int'(addr0), 0);
    chk("rst_pid", int'(pid0), 0);
    chk("rst_flags", int'({v0, b0, d0, step0}), 0);
    cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    // Start: address 1 fetched, then phrase 19 playing at step 0.
    start = 1'b1; cyc(); start = 1'b0;
    chk("start_addr", int'(addr0), 1);
    chk("fetch_busy", int'(b0), 1);
    chk("fetch_valid", int'(v0), 0);
    cyc();
    chk("play_pid", int'(pid0), 19);
    chk("play_valid", int'(v0), 1);
    chk("play_step", int'(step0), 0);

    // Sixteen ticks four clocks apart walk steps 0..15, then phrase 2.
    for (int i = 0; i < 16; i++) begin
      chk("walk_step", int'(step0), i);
      step_tick = 1'b1; cyc(); step_tick = 1'b0;
      if (i < 15) repeat (3) cyc();
    end
    chk("next_addr", int'(addr0), 2);
    chk("gap_valid", int'(v0), 0);
    chk("single_done", int'(d1), 1);
    chk("single_busy", int'(b1), 0);
    chk("single_pid", int'(pid1), 22);
    cyc();
    chk("next_pid", int'(pid0), 20);
    chk("next_valid", int'(v0), 1);

    // Start while busy is ignored; start in DONE restarts at 152.
    start = 1'b1; cyc(); start = 1'b0;
    chk("busy_ignore", int'(addr0), 2);
    chk("restart_addr", int'(addr1), 152);
    chk("restart_done", int'(d1), 0);

    // Tick during FETCH is carried into the first PLAY cycle.
    for (int i = 0; i < 15; i++) begin
      step_tick = 1'b1; cyc(); step_tick = 1'b0; cyc();
    end
    chk("pre_final", int'(step0), 15);
    step_tick = 1'b1; cyc();
    chk("fetch3_addr", int'(addr0), 3);
    cyc(); step_tick = 1'b0;
    chk("p3_pid", int'(pid0), 24);
    chk("p3_step0", int'(step0), 0);
    cyc();
    chk("pend_step", int'(step0), 1);

    // Stop together with a tick wins: idle, address and phrase held.
    step_tick = 1'b1; cyc();
    stop = 1'b1; cyc(); stop = 1'b0; step_tick = 1'b0;
    chk("stop_busy", int'(b0), 0);
    chk("stop_step", int'(step0), 0);
    chk("stop_valid", int'(v0), 0);
    chk("stop_addr", int'(addr0), 3);
    chk("stop_pid", int'(pid0), 24);

    // Loop mode on the single-phrase song re-fetches 152.
    loop_en = 1'b1;
    start = 1'b1; cyc(); start = 1'b0; cyc();
    for (int i = 0; i < 16; i++) begin
      step_tick = 1'b1; cyc(); step_tick = 1'b0;
      if (i == 15) begin
        chk("loop_addr", int'(addr1), 152);
        chk("loop_busy", int'(b1), 1);
        chk("loop_notdone", int'(d1), 0);
      end
      cyc();
    end
    chk("loop_pid", int'(pid1), 22);

    // Full song without loop: ends in DONE at the last address.
    stop = 1'b1; cyc(); stop = 1'b0; loop_en = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int c = 0; c < 20000 && d0 !== 1'b1; c++) begin
      step_tick = (c % 2 == 0); cyc();
    end
    step_tick = 1'b0;
    chk("song_done", int'(d0), 1);
    chk("song_addr", int'(addr0), 152);
    chk("song_pid", int'(pid0), 22);
    chk("song_busy", int'(b0), 0);
    chk("top_addr", int'(addr2), 255);
    chk("top_done", int'(d2), 1);
    chk("top_pid", int'(pid2), 28);
    cyc();

    // Asynchronous reset in the middle of PLAY.
    start = 1'b1; cyc(); start = 1'b0; cyc();
    step_tick = 1'b1; cyc(); step_tick = 1'b0; cyc();
    chk("pre_rst_step", int'(step0), 1);
    rst_n = 1'b0; #1;
    chk("arst_addr", int'(addr0), 0);
    chk("arst_pid", int'(pid0), 0);
    chk("arst_flags", int'({v0, b0, d0, step0}), 0);
    cyc(); rst_n = 1'b1; cyc(); cyc();
    chk("post_rst_busy", int'(b0), 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
